// File: rtl/weight_loader_pkg.sv
// Shared configuration for the weight path: array geometry, weight width and
// the weight_loader state encoding.
package Config;

  localparam int sys_cols       = 4;
  localparam int W_rows         = 3;
  localparam int W_BITWIDTH     = 8;
  localparam int w_buffer_depth = 16;
  localparam int W_TILE_WORDS   = W_rows * sys_cols;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } wl_state_t;

endpackage : Config

// File: rtl/weight_loader.sv
// Steers a row-major weight stream into per-column FIFOs, then streams the
// resident tile out of weight_buffer on start and pulses done once drained.
module weight_loader
  import Config::*;
#(
  parameter int SYS_COLS = Config::sys_cols,
  parameter int ROWS     = Config::W_rows,
  parameter int DW       = Config::W_BITWIDTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SYS_COLS-1:0] fifo_full,
  output logic [SYS_COLS-1:0] wr_en,
  output logic [DW-1:0]       din,
  input  logic                start,
  output logic                tile_ready,
  output logic                read,
  output logic                done
);

  localparam int CW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SYS_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] DR_LAST  = CW'((SYS_COLS > 1) ? (SYS_COLS - 2) : 0);

  wl_state_t     r_state;
  wl_state_t     w_state_nxt;
  logic [CW-1:0] r_col_idx;
  logic [RW-1:0] r_row_idx;
  logic [RW-1:0] r_rd_cnt;
  logic [CW-1:0] r_dr_cnt;
  logic          r_read;
  logic          r_done;
  logic          r_tile_ready;
  logic          w_in_ready;
  logic          w_xfer;
  logic          w_done_set;

  assign in_ready   = w_in_ready;
  assign din        = in_data;
  assign read       = r_read;
  assign done       = r_done;
  assign tile_ready = r_tile_ready;

  // Write-side handshake and one-hot steering; held off during the done pulse.
  always_comb begin
    w_in_ready = 1'b0;
    wr_en      = {SYS_COLS{1'b0}};
    if ((r_state == LOAD) && !r_done) begin
      w_in_ready = !fifo_full[r_col_idx];
    end else begin
      w_in_ready = 1'b0;
    end
    w_xfer = in_valid && w_in_ready;
    if (w_xfer) begin
      wr_en[r_col_idx] = 1'b1;
    end else begin
      wr_en = {SYS_COLS{1'b0}};
    end
  end

  // Next-state logic and done request.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_xfer && (r_col_idx == COL_LAST) && (r_row_idx == ROW_LAST)) begin
          w_state_nxt = READY;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      READY: begin
        if (start) begin
          w_state_nxt = STREAM;
        end else begin
          w_state_nxt = READY;
        end
      end
      STREAM: begin
        if (r_rd_cnt == ROW_LAST) begin
          if (SYS_COLS == 1) begin
            w_state_nxt = LOAD;
            w_done_set  = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else begin
          w_state_nxt = STREAM;
        end
      end
      DRAIN: begin
        if (r_dr_cnt == DR_LAST) begin
          w_state_nxt = LOAD;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_done_set  = 1'b0;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= LOAD;
      r_read       <= 1'b0;
      r_done       <= 1'b0;
      r_tile_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read       <= (w_state_nxt == STREAM);
      r_done       <= w_done_set;
      r_tile_ready <= (w_state_nxt == READY);
    end
  end

  // Load position: column wraps into the next row; both clear on the final word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col_idx <= {CW{1'b0}};
      r_row_idx <= {RW{1'b0}};
    end else if (w_xfer) begin
      if (r_col_idx == COL_LAST) begin
        r_col_idx <= {CW{1'b0}};
        r_row_idx <= (r_row_idx == ROW_LAST) ? {RW{1'b0}} : (r_row_idx + RW'(1));
      end else begin
        r_col_idx <= r_col_idx + CW'(1);
      end
    end
  end

  // Read and drain timers, idle at zero outside their states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_cnt <= {RW{1'b0}};
      r_dr_cnt <= {CW{1'b0}};
    end else begin
      if (r_state == STREAM) begin
        r_rd_cnt <= (r_rd_cnt == ROW_LAST) ? {RW{1'b0}} : (r_rd_cnt + RW'(1));
      end else begin
        r_rd_cnt <= {RW{1'b0}};
      end
      if (r_state == DRAIN) begin
        r_dr_cnt <= (r_dr_cnt == DR_LAST) ? {CW{1'b0}} : (r_dr_cnt + CW'(1));
      end else begin
        r_dr_cnt <= {CW{1'b0}};
      end
    end
  end

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a tile-level reference model checked every cycle.
module tb_weight_loader;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int DW   = 8;
  localparam int TILE = COLS * ROWS;
  localparam int LAT  = ROWS + COLS - 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = 8'h00;
  logic [COLS-1:0] fifo_full = 4'b0000;
  logic [COLS-1:0] wr_en;
  logic [DW-1:0]   din;
  logic            start = 1'b0;
  logic            tile_ready;
  logic            read;
  logic            done;

  always #5 clk = ~clk;

  weight_loader #(.SYS_COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fifo_full(fifo_full), .wr_en(wr_en), .din(din),
    .start(start), .tile_ready(tile_ready), .read(read), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile-level model: words accepted so far, whether a tile is resident,
  // and the edge at which streaming began.
  int cyc = 0;
  int m_t = 0;
  int m_k = 0;
  bit m_loaded = 1'b0;
  bit m_busy = 1'b0;

  int              d;
  logic            exp_ready;
  logic [COLS-1:0] exp_wr;
  logic            exp_read;
  logic            exp_done;
  logic            exp_tr;

  always_comb begin
    d         = cyc - m_t;
    exp_ready = !m_loaded && !m_busy && !fifo_full[m_k % COLS];
    exp_wr    = (in_valid && exp_ready) ? (4'b0001 << (m_k % COLS)) : 4'b0000;
    exp_read  = m_busy && (d < ROWS);
    exp_done  = m_busy && (d == LAT);
    exp_tr    = m_loaded;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_k      <= 0;
      m_loaded <= 1'b0;
      m_busy   <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (in_valid && exp_ready) begin
        if (m_k == TILE - 1) begin
          m_k      <= 0;
          m_loaded <= 1'b1;
        end else begin
          m_k <= m_k + 1;
        end
      end
      if (m_loaded && start) begin
        m_loaded <= 1'b0;
        m_busy   <= 1'b1;
        m_t      <= cyc + 1;
      end else if (m_busy && (cyc - m_t >= LAT)) begin
        m_busy <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, plus capture of what reached each FIFO.
  logic [DW-1:0]   mem [COLS][ROWS];
  int              cnt [COLS];
  logic [COLS-1:0] wlog [$];

  always @(negedge clk) begin
    check("in_ready", in_ready, exp_ready);
    check("wr_en", wr_en, exp_wr);
    check("read", read, exp_read);
    check("done", done, exp_done);
    check("tile_ready", tile_ready, exp_tr);
    if (wr_en != 4'b0000) begin
      check("din", din, in_data);
      wlog.push_back(wr_en);
      for (int c = 0; c < COLS; c++) begin
        if (wr_en[c]) begin
          if (cnt[c] < ROWS) mem[c][cnt[c]] <= din;
          cnt[c] <= cnt[c] + 1;
        end
      end
    end
  end

  task automatic clear_logs();
    wlog.delete();
    for (int c = 0; c < COLS; c++) cnt[c] = 0;
  endtask

  task automatic send_tile(input logic [DW-1:0] base, input int stall_k, input int stall_n);
    for (int k = 0; k < TILE; k++) begin
      int waited = 0;
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = base + 8'(k);
      if (k == stall_k) fifo_full[k % COLS] = 1'b1;
      while (!acc && waited < 50) begin
        if (k == stall_k && waited == stall_n) fifo_full = 4'b0000;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #2;
        waited++;
      end
      check("accept_timeout", 32'(acc), 32'd1);
    end
    in_valid  = 1'b0;
    fifo_full = 4'b0000;
  endtask

  task automatic check_tile(input logic [DW-1:0] base);
    for (int c = 0; c < COLS; c++) begin
      check("col_count", cnt[c], ROWS);
      for (int r = 0; r < ROWS; r++) check("col_data", mem[c][r], base + 8'(r * COLS + c));
    end
  endtask

  task automatic stream_check();
    logic rd [1:8];
    logic dn [1:8];
    logic ir [1:8];
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rd[i] = read;
      dn[i] = done;
      ir[i] = in_ready;
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
    end
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("read_T+%0d", i), rd[i], (i >= 1 && i <= 3) ? 1'b1 : 1'b0);
      check($sformatf("done_T+%0d", i), dn[i], (i == 7) ? 1'b1 : 1'b0);
    end
    check("in_ready_T+7", ir[7], 1'b0);
    check("in_ready_T+8", ir[8], 1'b1);
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wr_en", wr_en, 4'b0000);
    check("rst_read", read, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tile_ready", tile_ready, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b1;

    clear_logs();
    send_tile(8'h10, -1, 0);
    @(negedge clk);
    check("load1_tile_ready", tile_ready, 1'b1);
    check("load1_in_ready", in_ready, 1'b0);
    check("load1_nwrites", wlog.size(), 12);
    check("load1_w0", wlog[0], 4'b0001);
    check("load1_w1", wlog[1], 4'b0010);
    check("load1_w2", wlog[2], 4'b0100);
    check("load1_w3", wlog[3], 4'b1000);
    check("load1_w8", wlog[8], 4'b0001);
    check("load1_w11", wlog[11], 4'b1000);
    check("load1_c2e1", mem[2][1], 8'h16);
    check_tile(8'h10);
    @(posedge clk);
    #2;
    stream_check();

    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    clear_logs();
    send_tile(8'h40, 2, 5);
    @(negedge clk);
    check("load2_nwrites", wlog.size(), 12);
    check("load2_w2", wlog[2], 4'b0100);
    check("load2_c2e0", mem[2][0], 8'h42);
    check("load2_c3e2", mem[3][2], 8'h4b);
    check_tile(8'h40);

    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    check("abort_read_T+1", read, 1'b1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_read", read, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_tile_ready", tile_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    clear_logs();
    send_tile(8'h80, -1, 0);
    @(negedge clk);
    check("load3_w0", wlog[0], 4'b0001);
    check("load3_c0e0", mem[0][0], 8'h80);
    check("load3_tile_ready", tile_ready, 1'b1);
    check_tile(8'h80);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_weight_loader

// File: doc/weight_loader.md
# weight_loader

Upstream feeder for `weight_buffer`. It accepts a single valid/ready stream of weights in row-major tile order and steers each word into the per-column weight FIFOs through one-hot `wr_en` and a broadcast `din`. Once a complete `W_rows × sys_cols` tile is resident, it waits for `start`. It then drives `read` to `weight_buffer` for exactly `W_rows` cycles, waits for the skewed column reads to drain, and pulses `done`.

## Interface
Parameters:
- `SYS_COLS`, default `Config::sys_cols`: number of columns / FIFOs.
- `ROWS`, default `Config::W_rows`: weights per column per tile.
- `DW`, default `Config::W_BITWIDTH`: weight width.

Ports:
- `clk`: in, 1. Single clock.
- `rstn`: in, 1. Asynchronous, active-low reset.
- `in_valid`: in, 1. Weight word offered.
- `in_ready`: out, 1. Word accepted when `in_valid && in_ready`.
- `in_data`: in, `DW`. Weight word.
- `fifo_full`: in, `[SYS_COLS]`. Per-column FIFO full flags.
- `wr_en`: out, `[SYS_COLS]`. One-hot FIFO write strobe.
- `din`: out, `[DW]`. Write data, broadcast to all FIFOs.
- `start`: in, 1. Request streaming of the loaded tile.
- `tile_ready`: out, 1. A full tile is loaded and no stream is in progress.
- `read`: out, 1. Drives `weight_buffer.read`.
- `done`: out, 1. One-cycle pulse when all columns have been read.

## Operation
- FSM states: `LOAD`, `READY`, `STREAM`, `DRAIN`. Reset state is `LOAD`.
- Counters:
  - `col_idx`: `$clog2(SYS_COLS)` bits, 0..`SYS_COLS-1`.
  - `row_idx`: 0..`ROWS-1`.
  - `rd_cnt`: 0..`ROWS-1`.
  - `dr_cnt`: 0..`SYS_COLS-2`.
- In `LOAD`:
  - `in_ready = !fifo_full[col_idx]`.
  - A transfer is `in_valid && in_ready`.
  - On a transfer: `wr_en[col_idx] = 1` in the same cycle (combinational), `din = in_data`.
  - After each transfer, `col_idx` increments and wraps at `SYS_COLS-1`. On wrap, `row_idx` increments.
  - A transfer at `col_idx=SYS_COLS-1`, `row_idx=ROWS-1` moves the FSM to `READY`. Both counters clear.
- `in_ready = 0` in every state other than `LOAD`. `wr_en` is all zero whenever there is no transfer.
- `din` mirrors `in_data` at all times; it is only meaningful while `wr_en` is asserted.
- In `READY`:
  - `tile_ready = 1`.
  - `start` moves the FSM to `STREAM`.
  - `start` in any other state is ignored (no queuing).
- In `STREAM`:
  - `read = 1` (registered).
  - `rd_cnt` counts `ROWS` cycles, then the FSM moves to `DRAIN`.
  - If `SYS_COLS == 1`, the FSM goes straight from `STREAM` to `LOAD` and pulses `done` instead.
- In `DRAIN`:
  - `read = 0`.
  - The FSM waits `SYS_COLS-1` cycles for the skewed column reads, then returns to `LOAD` with `done = 1` for one cycle.
- `fifo_full` is only consulted for the targeted column. A full column stalls the whole stream, preserving word order.
- Row-major order: word `k` of a tile goes to column `k mod SYS_COLS`, as FIFO entry `k / SYS_COLS`.

## Timing
- Reset values (asynchronous, take effect immediately on `rstn` low):
  - `in_ready = !fifo_full[0]` (state `LOAD`, `col_idx=0`).
  - `wr_en = 0`, `tile_ready = 0`, `read = 0`, `done = 0`.
  - All counters 0.
- Write path has zero latency: the accepted word reaches the FIFO at the same clock edge it is accepted.
- Streaming sequence, with `start` sampled high in `READY` at edge T:
  - `tile_ready` falls after T.
  - `read` is high in cycles T+1 .. T+`ROWS`.
  - The FSM is in `DRAIN` in cycles T+`ROWS`+1 .. T+`ROWS`+`SYS_COLS`-1.
  - `done` is high in cycle T+`ROWS`+`SYS_COLS`.
  - `in_ready` may go high the cycle after `done`.
- Loading the next tile never overlaps streaming. `weight_buffer` therefore never sees a concurrent write and read.
- `rstn` asserted mid-load or mid-stream: the FSM aborts to `LOAD` and counters clear. Flushing partial FIFO contents is the system reset's responsibility.
- `in_valid` may drop between words without penalty. `in_data` must be held stable while `in_valid && !in_ready`.

## Structure
- `Config` package supplies `sys_cols`, `W_rows`, `W_BITWIDTH` and `w_buffer_depth`.
- Add to `Config`:
  - `typedef enum logic [1:0] {LOAD, READY, STREAM, DRAIN} wl_state_t`.
  - Localparam `W_TILE_WORDS = W_rows*sys_cols`.
- Single flat module; no sub-module is needed. The wrapper that pairs `weight_loader` with `weight_buffer` is a separate top.

## Test plan
All scenarios use `SYS_COLS=4`, `ROWS=3`, `DW=8`.
- **Reset:** hold `rstn=0` for 3 cycles, `fifo_full=0` -> `in_ready=1`, `wr_en=0`, `read=0`, `done=0`, `tile_ready=0`.
- **Ordering:** stream words 0..11 back-to-back -> `wr_en` sequence 0001, 0010, 0100, 1000, repeating three times. The cycle after word 11, `tile_ready=1` and `in_ready=0`.
- **Backpressure:** `fifo_full[2]=1` for 5 cycles while word 2 is offered -> no `wr_en` in those cycles; word 2 is written to column 2 once full drops; words 0..11 are still delivered in order.
- **Streaming:** `start` at edge T in `READY` -> `read` high in exactly cycles T+1..T+3, `done` high only in cycle T+7, `in_ready` high again at T+8.
- **Ignored start:** `start` pulsed while in `LOAD` and again during `STREAM` -> no change to `read` timing, no extra `done`.
- **Abort:** `rstn` low during `STREAM` (cycle T+2) -> `read=0` immediately, state `LOAD`; a following full 12-word load routes word 0 to column 0.
